// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the compressor arbiter: width defaults, clog2 and the
// output-slot state encoding.
package cmp_arb_pkg;

    localparam int DATA_WIDTH_DEF = 13;
    localparam int OUT_WIDTH_DEF  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_rr_pick.sv
// Rotating-priority picker: first asserted request at or after rr_ptr, wrapping
// modulo NREQ. Purely combinational.
module cmp_rr_pick #(
    parameter int NREQ     = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NREQ-1:0]     req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NREQ-1:0]     gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any_grant
);

    always_comb begin
        int j;
        logic [ID_WIDTH-1:0] jj;
        gnt       = '0;
        idx       = '0;
        any_grant = 1'b0;
        j         = 0;
        jj        = '0;
        for (int off = 0; off < NREQ; off++) begin
            j = int'(rr_ptr) + off;
            if (j >= NREQ) j = j - NREQ;
            jj = ID_WIDTH'(j);
            if (!any_grant && req[jj]) begin
                any_grant = 1'b1;
                gnt[jj]   = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/compress_arbiter.sv
// Round-robin sharing of one combinational 4:2 compressor between NREQ requesters.
// Define CMP_ARB_SKID_EN to turn the single output register into a 2-entry skid buffer.
module compress_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int ID_WIDTH   = clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*4*DATA_WIDTH-1:0] req_rows,
    output logic [DATA_WIDTH-1:0]        comp_in0,
    output logic [DATA_WIDTH-1:0]        comp_in1,
    output logic [DATA_WIDTH-1:0]        comp_in2,
    output logic [DATA_WIDTH-1:0]        comp_in3,
    input  logic [OUT_WIDTH-1:0]         comp_sum,
    input  logic [OUT_WIDTH-1:0]         comp_carry,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_sum,
    output logic [OUT_WIDTH-1:0]         out_carry,
    output logic [ID_WIDTH-1:0]          out_id
);

    localparam int RW = 4 * DATA_WIDTH;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] sum;
        logic [OUT_WIDTH-1:0] carry;
        logic [ID_WIDTH-1:0]  id;
    } result_t;

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [NREQ-1:0]     pick_gnt;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;
    logic                slot_free;
    logic                grant;
    logic [RW-1:0]       sel_rows;
    result_t             new_res;

    cmp_rr_pick #(
        .NREQ     (NREQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt       (pick_gnt),
        .idx       (pick_idx),
        .any_grant (pick_any)
    );

    assign grant     = slot_free & pick_any & ~rst;
    assign req_ready = grant ? pick_gnt : '0;

    // AND-OR mux gated by the qualified one-hot grant, so the compressor only
    // ever sees the winner's rows or zero.
    always_comb begin
        sel_rows = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) sel_rows = sel_rows | req_rows[i*RW +: RW];
        end
    end

    assign comp_in0 = sel_rows[0*DATA_WIDTH +: DATA_WIDTH];
    assign comp_in1 = sel_rows[1*DATA_WIDTH +: DATA_WIDTH];
    assign comp_in2 = sel_rows[2*DATA_WIDTH +: DATA_WIDTH];
    assign comp_in3 = sel_rows[3*DATA_WIDTH +: DATA_WIDTH];

    assign new_res = '{sum: comp_sum, carry: comp_carry, id: pick_idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
        end
    end

`ifdef CMP_ARB_SKID_EN
    result_t    ent0, ent1;
    logic [1:0] cnt, cnt_nxt;
    logic       pop;

    // Grant looks only at registered occupancy, breaking the out_ready -> req_ready path.
    assign slot_free = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign cnt_nxt   = cnt + {1'b0, grant} - {1'b0, pop};
    assign out_sum   = ent0.sum;
    assign out_carry = ent0.carry;
    assign out_id    = ent0.id;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            cnt   <= 2'd0;
            state <= IDLE;
        end else begin
            case ({pop, grant})
                2'b01: begin
                    if (cnt == 2'd0) ent0 <= new_res;
                    else             ent1 <= new_res;
                end
                2'b10: ent0 <= ent1;
                2'b11: begin
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= new_res;
                    end else begin
                        ent0 <= new_res;
                    end
                end
                default: ;
            endcase
            cnt <= cnt_nxt;
            if (cnt_nxt == 2'd0)            state <= IDLE;
            else if (out_valid && !out_ready) state <= STALL;
            else                              state <= BUSY;
        end
    end
`else
    result_t res_q;

    assign slot_free = (state == IDLE) | out_ready;
    assign out_sum   = res_q.sum;
    assign out_carry = res_q.carry;
    assign out_id    = res_q.id;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            if (grant) res_q <= new_res;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                    end
                end
                BUSY, STALL: begin
                    if (!out_ready) begin
                        state <= STALL;
                    end else if (grant) begin
                        state <= BUSY;
                    end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_compress_arbiter.sv
// Randomized scoreboard bench for compress_arbiter; a reference model predicts
// grants and results, a monitor pops and compares the presented outputs.
module tb_compress_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 13;
    localparam int OW   = 16;
    localparam int IDW  = 2;
`ifdef CMP_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*4*DW-1:0]   req_rows = '0;
    logic [DW-1:0]          comp_in0, comp_in1, comp_in2, comp_in3;
    logic [OW-1:0]          comp_sum, comp_carry;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [OW-1:0]          out_sum, out_carry;
    logic [IDW-1:0]         out_id;

    always #5 clk = ~clk;

    compress_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rows(req_rows),
        .comp_in0(comp_in0), .comp_in1(comp_in1), .comp_in2(comp_in2), .comp_in3(comp_in3),
        .comp_sum(comp_sum), .comp_carry(comp_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_id(out_id)
    );

    // Stand-in compressor: xor for sum, majority shifted left for carry.
    function automatic logic [OW-1:0] f_sum(input logic [DW-1:0] a, b, c, d);
        return OW'(a ^ b ^ c ^ d);
    endfunction

    function automatic logic [OW-1:0] f_carry(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] m;
        m = (a & b) | (a & c) | (b & c);
        return OW'({m, 1'b0});
    endfunction

    always_comb begin
        comp_sum   = f_sum(comp_in0, comp_in1, comp_in2, comp_in3);
        comp_carry = f_carry(comp_in0, comp_in1, comp_in2);
    end

    typedef struct {
        logic [OW-1:0] s;
        logic [OW-1:0] c;
        int            id;
    } res_t;

    res_t sb[$];
    int   ptr    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   popped = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented result whenever the downstream accepts it.
    always @(negedge clk) begin
        res_t e;
        popped = 1'b0;
        if (!rst) begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                popped = 1'b1;
                chk("out_sum", 64'(out_sum), 64'(e.s));
                chk("out_carry", 64'(out_carry), 64'(e.c));
                chk("out_id", 64'(out_id), 64'(e.id));
            end
        end
    end

    // Reference model: decides who should win this cycle and what it produces.
    always @(negedge clk) begin
        int occ, win;
        bit free;
        logic [NREQ-1:0] exp_rdy;
        logic [4*DW-1:0] r;
        res_t e;
        #1;
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
        end else begin
            occ  = sb.size() + int'(popped);
            free = SKID ? (occ < 2) : (occ == 0 || out_ready);
            win  = -1;
            if (free) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (win < 0 && req_valid[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
                end
            end
            exp_rdy = '0;
            r       = '0;
            if (win >= 0) begin
                exp_rdy[win] = 1'b1;
                r = req_rows[win*4*DW +: 4*DW];
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("comp_in", 64'({comp_in3, comp_in2, comp_in1, comp_in0}), 64'(r));
            if (win >= 0) begin
                e.s  = f_sum(r[0 +: DW], r[DW +: DW], r[2*DW +: DW], r[3*DW +: DW]);
                e.c  = f_carry(r[0 +: DW], r[DW +: DW], r[2*DW +: DW]);
                e.id = win;
                sb.push_back(e);
                ptr = (win + 1) % NREQ;
            end
        end
    end

    task automatic step(input logic [NREQ-1:0] v, input logic rdy);
        @(posedge clk);
        #1;
        req_valid = v;
        out_ready = rdy;
        for (int i = 0; i < NREQ * 4; i++) req_rows[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        // Reset with every requester asking.
        rst = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_carry", 64'(out_carry), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All valid, free-running downstream.
        repeat (8) step(4'hF, 1'b1);

        // Single requester 2 with in0=1.
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        req_rows  = '0;
        req_rows[2*4*DW +: DW] = 13'h1;
        step(4'h0, 1'b1);
        @(negedge clk);
        chk("req2_valid", 64'(out_valid), 64'd1);
        chk("req2_sum", 64'(out_sum), 64'h1);
        chk("req2_carry", 64'(out_carry), 64'h0);
        chk("req2_id", 64'(out_id), 64'd2);

        // Backpressure then release.
        repeat (3) step(4'hF, 1'b0);
        repeat (3) step(4'hF, 1'b1);

        // Sparse requesters starting from rr_ptr=2.
        repeat (3) step(4'h0, 1'b1);
        step(4'b0010, 1'b1);
        repeat (4) step(4'b1010, 1'b1);

        // Toggling downstream ready.
        for (int i = 0; i < 8; i++) step(4'hF, (i % 2) == 0);

        // Random traffic.
        repeat (500) step(NREQ'($urandom), $urandom_range(0, 3) != 0);

        // Reset in the middle of traffic drops any held result.
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        ptr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) step(NREQ'($urandom), $urandom_range(0, 2) != 0);

        repeat (4) step(4'h0, 1'b1);
        @(negedge clk);
        #2;
        chk("drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
